bin_to_bcd_seq: RTL



---
 rtl/bcd_pkg.sv | 24 ++
 rtl/bcd_add3.sv | 15 +
 rtl/bin_to_bcd_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared types and constants for the sequential binary-to-BCD path.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    // Code the seven-segment decoder renders as all segments off.
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    // Decimal digits needed for 2^width-1: floor(width*log10(2)) + 1.
    function automatic int min_digits(input int width);
        return (width * 30103) / 100000 + 1;
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
// Module   : bcd_add3
// Brief    : Double-dabble nibble correction: add 3 when the digit is >= 5.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule : bcd_add3
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Brief    : Sequential shift-and-add-3 binary-to-BCD converter, one bit/clock.
//            Optional macro BCD_LZ_BLANK_EN blanks leading zero digits to 4'hF.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int c_bcd_w = 4 * DIGITS;
    localparam int c_sr_w  = c_bcd_w + WIDTH;
    localparam int c_cnt_w = $clog2(WIDTH + 1);

    generate
        if (DIGITS < min_digits(WIDTH)) begin : g_digits_too_small
            $fatal(1, "bin_to_bcd_seq: DIGITS too small for WIDTH");
        end
    endgenerate

    bcd_state_t           r_state;
    bcd_state_t           w_state_nxt;
    logic [c_sr_w-1:0]    r_shift;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_bcd_w-1:0]   r_bcd;

    logic                 w_load;
    logic                 w_shift_en;
    logic                 w_capture;
    logic [c_bcd_w-1:0]   w_corr_bcd;
    logic [c_sr_w-1:0]    w_shift_nxt;
    logic [c_bcd_w-1:0]   w_final_bcd;
    logic [c_bcd_w-1:0]   w_result;
    logic                 w_unused_msb;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_add3
            bcd_add3 u_add3 (
                .din  (r_shift[WIDTH + 4*k +: 4]),
                .dout (w_corr_bcd[4*k +: 4])
            );
        end
    endgenerate

    // The top BCD bit cannot be set before a shift when DIGITS is large enough.
    assign w_unused_msb = w_corr_bcd[c_bcd_w-1];
    assign w_shift_nxt  = {w_corr_bcd[c_bcd_w-2:0], r_shift[WIDTH-1:0], 1'b0};
    assign w_final_bcd  = w_shift_nxt[c_sr_w-1 -: c_bcd_w];

`ifdef BCD_LZ_BLANK_EN
    always_comb begin
        logic v_lead;
        w_result = w_final_bcd;
        v_lead   = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (v_lead && (w_final_bcd[4*k +: 4] == 4'd0)) begin
                w_result[4*k +: 4] = BCD_BLANK;
            end else begin
                v_lead = 1'b0;
            end
        end
    end
`else
    assign w_result = w_final_bcd;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift_en  = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_shift_en = 1'b1;
                if (r_cnt == c_cnt_w'(1)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_shift <= {{c_bcd_w{1'b0}}, bin_in};
                r_cnt   <= c_cnt_w'(WIDTH);
            end else if (w_shift_en) begin
                r_shift <= w_shift_nxt;
                r_cnt   <= r_cnt - c_cnt_w'(1);
            end
            if (w_capture) begin
                r_bcd <= w_result;
            end
        end
    end

    assign busy    = (r_state == SHIFT);
    assign done    = (r_state == DONE);
    assign bcd_out = r_bcd;

endmodule : bin_to_bcd_seq
`default_nettype wire
